mem_mp_bank: RTL and testbench

//  Parametrised multi-port register-file memory for data/instruction storage in the core.
//  - Adds to the basic R/W array: per-byte write enables, write-port priority,

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_rd_pipe.sv | 35 +++
 rtl/mem_mp_bank.sv | 131 +++++++++++++
 tb/tb_mem_mp_bank.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the multi-port register-file bank.
package mem_pkg;

   localparam int unsigned MAX_READ_LATENCY = 3;

   typedef enum logic {ST_CLEAR, ST_IDLE} mem_state_t;

   function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       be);
      return be ? new_b : old_b;
   endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Per-port read return path: capture register followed by LATENCY-1 delay stages.
module mem_rd_pipe #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [LATENCY-1:0]            v;
   logic [LATENCY-1:0][WIDTH-1:0] d;

   // Data stages only load alongside a valid, so the last stage holds the previous result.
   always_ff @(posedge clk) begin
      if (rst) begin
         v <= '0;
         d <= '0;
      end else begin
         v[0] <= in_valid;
         if (in_valid) d[0] <= in_data;
         for (int unsigned k = 1; k < LATENCY; k++) begin
            v[k] <= v[k-1];
            if (v[k-1]) d[k] <= d[k-1];
         end
      end
   end

   assign out_valid = v[LATENCY-1];
   assign out_data  = d[LATENCY-1];

endmodule

// File: rtl/mem_mp_bank.sv
// Multi-port register-file bank with byte enables, write priority, write-first
// read bypass, configurable read latency and a hardware clear sequencer.
module mem_mp_bank
   import mem_pkg::*;
#(
   parameter  int unsigned IO_SIZE      = 32,
   parameter  int unsigned ROWS         = 64,
   parameter  int unsigned READ_PORTS   = 2,
   parameter  int unsigned WRITE_PORTS  = 1,
   parameter  int unsigned READ_LATENCY = 1,
   localparam int unsigned AW           = $clog2(ROWS),
   localparam int unsigned NB           = IO_SIZE / 8
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [WRITE_PORTS-1:0]                 EnWrite,
   input  logic [WRITE_PORTS-1:0][AW-1:0]         write_addr,
   input  logic [WRITE_PORTS-1:0][IO_SIZE-1:0]    write_data,
   input  logic [WRITE_PORTS-1:0][NB-1:0]         write_be,
   input  logic [READ_PORTS-1:0]                  read_en,
   input  logic [READ_PORTS-1:0][AW-1:0]          read_addr,
   output logic [READ_PORTS-1:0][IO_SIZE-1:0]     read_data,
   output logic [READ_PORTS-1:0]                  read_valid,
   input  logic                                   init_req,
   output logic                                   busy
);

   localparam int unsigned PIPE_LAT  = (READ_LATENCY < 1) ? 1 :
                                       (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                                       READ_LATENCY;
   localparam logic [AW:0]   ROW_LIMIT = (AW+1)'(ROWS);
   localparam logic [AW-1:0] LAST_ROW  = AW'(ROWS - 1);

   logic [IO_SIZE-1:0] mem [ROWS];

   mem_state_t                            state;
   logic [AW-1:0]                         clr_ptr;
   logic [WRITE_PORTS-1:0]                wr_acc;
   logic [READ_PORTS-1:0]                 rd_acc;
   logic [READ_PORTS-1:0]                 rd_in_range;
   logic [READ_PORTS-1:0][IO_SIZE-1:0]    rd_word;

   always_comb begin
      wr_acc = '0;
      for (int unsigned c = 0; c < WRITE_PORTS; c++)
         wr_acc[c] = EnWrite[c] && !busy && !rst && ({1'b0, write_addr[c]} < ROW_LIMIT);
   end

   always_comb begin
      rd_acc      = '0;
      rd_in_range = '0;
      for (int unsigned i = 0; i < READ_PORTS; i++) begin
         rd_acc[i]      = read_en[i] && !busy && !rst;
         rd_in_range[i] = ({1'b0, read_addr[i]} < ROW_LIMIT);
      end
   end

   // Bypass: later write ports overlay earlier ones, mirroring the array update priority.
   always_comb begin
      rd_word = '0;
      for (int unsigned i = 0; i < READ_PORTS; i++) begin
         if (rd_in_range[i]) begin
            rd_word[i] = mem[read_addr[i]];
            for (int unsigned c = 0; c < WRITE_PORTS; c++)
               for (int unsigned b = 0; b < NB; b++)
                  if (wr_acc[c] && write_addr[c] == read_addr[i])
                     rd_word[i][8*b +: 8] = byte_merge(rd_word[i][8*b +: 8],
                                                       write_data[c][8*b +: 8],
                                                       write_be[c][b]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == ST_CLEAR) begin
            mem[clr_ptr] <= '0;
         end else begin
            for (int unsigned c = 0; c < WRITE_PORTS; c++)
               for (int unsigned b = 0; b < NB; b++)
                  if (wr_acc[c] && write_be[c][b])
                     mem[write_addr[c]][8*b +: 8] <= write_data[c][8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_CLEAR;
         clr_ptr <= '0;
         busy    <= 1'b1;
      end else begin
         case (state)
            ST_CLEAR: begin
               clr_ptr <= clr_ptr + 1'b1;
               if (clr_ptr == LAST_ROW) begin
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
                  clr_ptr <= '0;
               end
            end
            ST_IDLE: begin
               if (init_req) begin
                  state   <= ST_CLEAR;
                  busy    <= 1'b1;
                  clr_ptr <= '0;
               end
            end
            default: begin
               state <= ST_CLEAR;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rd
      mem_rd_pipe #(
         .WIDTH   (IO_SIZE),
         .LATENCY (PIPE_LAT)
      ) u_pipe (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (rd_acc[gi]),
         .in_data   (rd_word[gi]),
         .out_valid (read_valid[gi]),
         .out_data  (read_data[gi])
      );
   end

endmodule

// File: tb/tb_mem_mp_bank.sv
// Bench for mem_mp_bank: two instances (read latency 1 and 3) share one stimulus
// stream and are compared each cycle against a word-array model with result queues.
module tb_mem_mp_bank;

   localparam int ROWS = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst;
   logic [1:0]           en_w;
   logic [1:0][5:0]      wa;
   logic [1:0][31:0]     wd;
   logic [1:0][3:0]      wbe;
   logic [1:0]           ren;
   logic [1:0][5:0]      ra;
   logic                 init_req;
   logic [1:0][31:0]     rd1, rd3;
   logic [1:0]           rv1, rv3;
   logic                 busy1, busy3;

   mem_mp_bank #(
      .IO_SIZE(32), .ROWS(ROWS), .READ_PORTS(2), .WRITE_PORTS(2), .READ_LATENCY(1)
   ) u_dut1 (
      .clk(clk), .rst(rst), .EnWrite(en_w), .write_addr(wa), .write_data(wd),
      .write_be(wbe), .read_en(ren), .read_addr(ra), .read_data(rd1),
      .read_valid(rv1), .init_req(init_req), .busy(busy1)
   );

   mem_mp_bank #(
      .IO_SIZE(32), .ROWS(ROWS), .READ_PORTS(2), .WRITE_PORTS(2), .READ_LATENCY(3)
   ) u_dut3 (
      .clk(clk), .rst(rst), .EnWrite(en_w), .write_addr(wa), .write_data(wd),
      .write_be(wbe), .read_en(ren), .read_addr(ra), .read_data(rd3),
      .read_valid(rv3), .init_req(init_req), .busy(busy3)
   );

   typedef struct {
      int          due;
      logic [31:0] data;
   } rd_t;

   logic [31:0] mmem [ROWS];
   bit          m_busy;
   int          clr;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_err = 0;
   int          lat [2] = '{1, 3};
   rd_t         rq [4][$];
   logic        exp_v  [2][2];
   logic [31:0] exp_d  [2][2];
   logic [31:0] last_d [2][2];

   function automatic logic obs_v(int d, int i);
      return (d == 0) ? rv1[i] : rv3[i];
   endfunction

   function automatic logic [31:0] obs_d(int d, int i);
      return (d == 0) ? rd1[i] : rd3[i];
   endfunction

   task automatic idle_inputs();
      rst = 1'b0; en_w = '0; wa = '0; wd = '0; wbe = '0;
      ren = '0; ra = '0; init_req = 1'b0;
   endtask

   task automatic random_inputs();
      en_w = 2'($urandom); ren = 2'($urandom); init_req = 1'($urandom);
      for (int c = 0; c < 2; c++) begin
         wa[c] = 6'($urandom_range(0, ROWS - 1));
         wd[c] = $urandom;
         wbe[c] = 4'($urandom);
         ra[c] = 6'($urandom_range(0, ROWS - 1));
      end
   endtask

   // One clock: model consumes the current inputs, then expectations are refreshed.
   task automatic tick();
      if (rst) begin
         m_busy = 1'b1;
         clr = 0;
         for (int k = 0; k < 4; k++) rq[k].delete();
         for (int d = 0; d < 2; d++) for (int i = 0; i < 2; i++) last_d[d][i] = '0;
      end else if (m_busy) begin
         mmem[clr] = '0;
         clr++;
         if (clr == ROWS) m_busy = 1'b0;
      end else begin
         for (int c = 0; c < 2; c++)
            if (en_w[c])
               for (int b = 0; b < 4; b++)
                  if (wbe[c][b]) mmem[wa[c]][8*b +: 8] = wd[c][8*b +: 8];
         for (int i = 0; i < 2; i++)
            if (ren[i])
               for (int d = 0; d < 2; d++)
                  rq[d*2+i].push_back('{due: cyc + lat[d], data: mmem[ra[i]]});
         if (init_req) begin
            m_busy = 1'b1;
            clr = 0;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 2; i++) begin
            int k = d*2 + i;
            exp_v[d][i] = 1'b0;
            if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
               exp_v[d][i] = 1'b1;
               last_d[d][i] = rq[k][0].data;
               void'(rq[k].pop_front());
            end
            exp_d[d][i] = last_d[d][i];
         end
   endtask

   task automatic test_reset();
      int busy_cycles = 0;
      for (int t = 0; t < 70; t++) begin
         if (t == 0 || m_busy) random_inputs(); else idle_inputs();
         rst = (t == 0);
         tick();
         if (busy1) busy_cycles++;
         n_checks++;
         if (busy1 !== m_busy || busy3 !== m_busy) begin
            n_err++;
            $display("FAIL reset_busy cyc%0d: got %b/%b, want %b", cyc, busy1, busy3, m_busy);
         end
         for (int d = 0; d < 2; d++) for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_v(d, i) !== exp_v[d][i] || obs_d(d, i) !== exp_d[d][i]) begin
               n_err++;
               $display("FAIL reset_rd cyc%0d rl%0d p%0d: got v=%b d=%h, want v=%b d=%h",
                        cyc, lat[d], i, obs_v(d, i), obs_d(d, i), exp_v[d][i], exp_d[d][i]);
            end
         end
      end
      n_checks++;
      if (busy_cycles != 64) begin
         n_err++;
         $display("FAIL reset_busy_len: got %0d cycles, want 64", busy_cycles);
      end
   endtask

   task automatic test_zero_rows();
      for (int t = 0; t < ROWS + 3; t++) begin
         idle_inputs();
         if (t < ROWS) begin
            ren = 2'b11; ra[0] = 6'(t); ra[1] = 6'(ROWS - 1 - t);
         end
         tick();
         for (int d = 0; d < 2; d++) for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_v(d, i) !== exp_v[d][i] || obs_d(d, i) !== exp_d[d][i]) begin
               n_err++;
               $display("FAIL zero_rows cyc%0d rl%0d p%0d: got v=%b d=%h, want v=%b d=%h",
                        cyc, lat[d], i, obs_v(d, i), obs_d(d, i), exp_v[d][i], exp_d[d][i]);
            end
         end
      end
   endtask

   task automatic test_byte_enable();
      for (int t = 0; t < 6; t++) begin
         idle_inputs();
         if (t == 0) begin en_w = 2'b01; wa[0] = 6'd5; wd[0] = 32'hDEADBEEF; wbe[0] = 4'hF; end
         if (t == 1) begin en_w = 2'b01; wa[0] = 6'd5; wd[0] = 32'h000000AA; wbe[0] = 4'b0001; end
         if (t == 2) begin ren = 2'b11; ra[0] = 6'd5; ra[1] = 6'd5; end
         tick();
         for (int d = 0; d < 2; d++) for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_v(d, i) !== exp_v[d][i] || obs_d(d, i) !== exp_d[d][i]) begin
               n_err++;
               $display("FAIL byte_en cyc%0d rl%0d p%0d: got v=%b d=%h, want v=%b d=%h",
                        cyc, lat[d], i, obs_v(d, i), obs_d(d, i), exp_v[d][i], exp_d[d][i]);
            end
         end
         if (t == 2) begin
            n_checks++;
            if (rv1[0] !== 1'b1 || rd1[0] !== 32'hDEADBEAA) begin
               n_err++;
               $display("FAIL byte_en_const: got v=%b d=%h, want v=1 d=deadbeaa", rv1[0], rd1[0]);
            end
         end
      end
   endtask

   task automatic test_priority();
      for (int t = 0; t < 5; t++) begin
         idle_inputs();
         if (t == 0) begin
            en_w = 2'b11; wa[0] = 6'd3; wa[1] = 6'd3;
            wd[0] = 32'h11111111; wd[1] = 32'h22222222; wbe[0] = 4'hF; wbe[1] = 4'b0011;
         end
         if (t == 1) begin ren = 2'b01; ra[0] = 6'd3; end
         tick();
         for (int d = 0; d < 2; d++) for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_v(d, i) !== exp_v[d][i] || obs_d(d, i) !== exp_d[d][i]) begin
               n_err++;
               $display("FAIL priority cyc%0d rl%0d p%0d: got v=%b d=%h, want v=%b d=%h",
                        cyc, lat[d], i, obs_v(d, i), obs_d(d, i), exp_v[d][i], exp_d[d][i]);
            end
         end
         if (t == 1) begin
            n_checks++;
            if (rv1[0] !== 1'b1 || rd1[0] !== 32'h11112222) begin
               n_err++;
               $display("FAIL priority_const: got v=%b d=%h, want v=1 d=11112222", rv1[0], rd1[0]);
            end
         end
      end
   endtask

   task automatic test_bypass();
      for (int t = 0; t < 5; t++) begin
         idle_inputs();
         if (t == 0) begin
            en_w = 2'b01; wa[0] = 6'd7; wd[0] = 32'h12345678; wbe[0] = 4'hF;
            ren = 2'b11; ra[0] = 6'd7; ra[1] = 6'd7;
         end
         tick();
         for (int d = 0; d < 2; d++) for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_v(d, i) !== exp_v[d][i] || obs_d(d, i) !== exp_d[d][i]) begin
               n_err++;
               $display("FAIL bypass cyc%0d rl%0d p%0d: got v=%b d=%h, want v=%b d=%h",
                        cyc, lat[d], i, obs_v(d, i), obs_d(d, i), exp_v[d][i], exp_d[d][i]);
            end
         end
         n_checks++;
         if (rv3[0] !== (t == 2) || (t == 2 && rd3[0] !== 32'h12345678)) begin
            n_err++;
            $display("FAIL bypass_lat3 t%0d: got v=%b d=%h, want v=%b d=12345678",
                     t, rv3[0], rd3[0], (t == 2));
         end
      end
   endtask

   task automatic test_back_to_back();
      int nv [2][2] = '{'{0, 0}, '{0, 0}};
      for (int t = 0; t < 24; t++) begin
         idle_inputs();
         if (t < 10) begin en_w = 2'b01; wa[0] = 6'(t); wd[0] = $urandom; wbe[0] = 4'hF; end
         else if (t < 20) begin ren = 2'b11; ra[0] = 6'(t - 10); ra[1] = 6'(19 - t); end
         tick();
         for (int d = 0; d < 2; d++) for (int i = 0; i < 2; i++) begin
            if (obs_v(d, i) === 1'b1) nv[d][i]++;
            n_checks++;
            if (obs_v(d, i) !== exp_v[d][i] || obs_d(d, i) !== exp_d[d][i]) begin
               n_err++;
               $display("FAIL stream cyc%0d rl%0d p%0d: got v=%b d=%h, want v=%b d=%h",
                        cyc, lat[d], i, obs_v(d, i), obs_d(d, i), exp_v[d][i], exp_d[d][i]);
            end
         end
      end
      for (int d = 0; d < 2; d++) for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (nv[d][i] != 10) begin
            n_err++;
            $display("FAIL stream_count rl%0d p%0d: got %0d valids, want 10", lat[d], i, nv[d][i]);
         end
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 300; t++) begin
         random_inputs();
         init_req = ($urandom_range(0, 49) == 0);
         tick();
         n_checks++;
         if (busy1 !== m_busy || busy3 !== m_busy) begin
            n_err++;
            $display("FAIL random_busy cyc%0d: got %b/%b, want %b", cyc, busy1, busy3, m_busy);
         end
         for (int d = 0; d < 2; d++) for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_v(d, i) !== exp_v[d][i] || obs_d(d, i) !== exp_d[d][i]) begin
               n_err++;
               $display("FAIL random cyc%0d rl%0d p%0d: got v=%b d=%h, want v=%b d=%h",
                        cyc, lat[d], i, obs_v(d, i), obs_d(d, i), exp_v[d][i], exp_d[d][i]);
            end
         end
      end
      // let any clear started above finish before the next scenario
      for (int t = 0; t < ROWS + 4; t++) begin
         idle_inputs();
         tick();
      end
   endtask

   task automatic test_inflight_clear();
      int busy_after_rst = 0;
      for (int t = 0; t < 92; t++) begin
         idle_inputs();
         if (t == 0) begin
            en_w = 2'b01; wa[0] = 6'd7; wd[0] = 32'hCAFEF00D; wbe[0] = 4'hF;
         end
         if (t == 1) begin ren = 2'b01; ra[0] = 6'd7; end
         if (t == 2) begin
            init_req = 1'b1;
            en_w = 2'b01; wa[0] = 6'd7; wd[0] = 32'h0BADC0DE; wbe[0] = 4'hF;
         end
         if (t == 23) rst = 1'b1;
         tick();
         if (t >= 23 && busy1 === 1'b1) busy_after_rst++;
         n_checks++;
         if (busy1 !== m_busy || busy3 !== m_busy) begin
            n_err++;
            $display("FAIL clear_busy cyc%0d: got %b/%b, want %b", cyc, busy1, busy3, m_busy);
         end
         for (int d = 0; d < 2; d++) for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_v(d, i) !== exp_v[d][i] || obs_d(d, i) !== exp_d[d][i]) begin
               n_err++;
               $display("FAIL clear_rd cyc%0d rl%0d p%0d: got v=%b d=%h, want v=%b d=%h",
                        cyc, lat[d], i, obs_v(d, i), obs_d(d, i), exp_v[d][i], exp_d[d][i]);
            end
         end
         if (t == 3) begin
            n_checks++;
            if (rv3[0] !== 1'b1 || rd3[0] !== 32'hCAFEF00D) begin
               n_err++;
               $display("FAIL inflight_const: got v=%b d=%h, want v=1 d=cafef00d", rv3[0], rd3[0]);
            end
         end
      end
      n_checks++;
      if (busy_after_rst != 64) begin
         n_err++;
         $display("FAIL rst_mid_clear: got %0d busy cycles, want 64", busy_after_rst);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_zero_rows();
      test_byte_enable();
      test_priority();
      test_bypass();
      test_back_to_back();
      test_random();
      test_inflight_clear();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
